// File: rtl/demux_pkt_sched.sv
// Packet-aware 1-to-2 demux scheduler: picks a channel per packet,
// steers beats through one holding register and counts packets per channel.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   cfg_en/mode/ch       scheduler enable, 0=round-robin 1=fixed, fixed channel
//   in_valid/data/last   upstream beat stream, in_ready back-pressure
//   outN_valid/data/last downstream channel N beat (zeroed when not valid)
//   outN_ready           downstream ready for channel N
//   pkt_cnt0/1           packets completed per channel (wrapping)
//   busy                 mid-packet or holding register occupied
module demux_pkt_sched #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_en,
   input  logic             cfg_mode,
   input  logic             cfg_ch,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out0_valid,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_last,
   input  logic             out0_ready,
   output logic             out1_valid,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_last,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1,
   output logic             busy
);

   typedef enum logic {IDLE, PKT} state_t;

   state_t           state_q, state_d;
   logic             pkt_ch_q, pkt_ch_d;
   logic             rr_q, rr_d;
   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] hold_data_q, hold_data_d;
   logic             hold_last_q, hold_last_d;
   logic             hold_ch_q, hold_ch_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic drain;
   logic accept;
   logic ch_sel;

   assign drain  = hold_valid_q & (hold_ch_q ? out1_ready : out0_ready);
   assign accept = in_valid & in_ready;

   // Channel decision is only taken at a packet start; mid-packet beats
   // reuse the latched channel so config changes cannot split a packet.
   assign ch_sel = (state_q == IDLE) ? (cfg_mode ? cfg_ch : rr_q)
                                     : pkt_ch_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pkt_ch_q     <= 1'b0;
         rr_q         <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
         hold_ch_q    <= 1'b0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q      <= state_d;
         pkt_ch_q     <= pkt_ch_d;
         rr_q         <= rr_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         hold_ch_q    <= hold_ch_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pkt_ch_d = pkt_ch_q;
      rr_d     = rr_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               pkt_ch_d = ch_sel;
               if (!cfg_mode) rr_d = ~rr_q;
               if (!in_last) state_d = PKT;
            end
         end
         PKT: begin
            if (accept && in_last) state_d = IDLE;
         end
      endcase
   end

   // in_ready is forced low while reset is asserted, independent of cfg_en.
   always_comb begin
      in_ready = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: in_ready = cfg_en & (~hold_valid_q | drain);
            PKT:  in_ready = ~hold_valid_q | drain;
         endcase
      end
   end

   // A new beat may load in the same cycle the old one drains, so a
   // channel switch at a packet boundary costs no bubble.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      hold_ch_d    = hold_ch_q;
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = in_data;
         hold_last_d  = in_last;
         hold_ch_d    = ch_sel;
      end else if (drain) begin
         hold_valid_d = 1'b0;
      end
   end

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (drain && hold_last_q) begin
         if (hold_ch_q) cnt1_d = cnt1_q + 1'b1;
         else           cnt0_d = cnt0_q + 1'b1;
      end
   end

   assign out0_valid = hold_valid_q & ~hold_ch_q;
   assign out1_valid = hold_valid_q &  hold_ch_q;
   assign out0_data  = out0_valid ? hold_data_q : '0;
   assign out1_data  = out1_valid ? hold_data_q : '0;
   assign out0_last  = out0_valid & hold_last_q;
   assign out1_last  = out1_valid & hold_last_q;

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
   assign busy     = (state_q == PKT) | hold_valid_q;

endmodule

// File: tb/tb_demux_pkt_sched.sv
// Directed testbench for demux_pkt_sched.
// Instance uses CNT_W=2 so counter wrap is reachable quickly.
module tb_demux_pkt_sched;

   localparam int W = 4;
   localparam int CW = 2;

   logic          clk = 0;
   logic          rst_n;
   logic          cfg_en, cfg_mode, cfg_ch;
   logic          in_valid, in_last, in_ready;
   logic [W-1:0]  in_data;
   logic          out0_valid, out0_last, out0_ready;
   logic          out1_valid, out1_last, out1_ready;
   logic [W-1:0]  out0_data, out1_data;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1;
   logic          busy;

   int n_run = 0;
   int n_fail = 0;
   int e0 = 0;
   int e1 = 0;

   always #5 clk = ~clk;

   demux_pkt_sched #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_ch(cfg_ch),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready),
      .out0_valid(out0_valid), .out0_data(out0_data),
      .out0_last(out0_last), .out0_ready(out0_ready),
      .out1_valid(out1_valid), .out1_data(out1_data),
      .out1_last(out1_last), .out1_ready(out1_ready),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
   endtask

   task automatic exp_out(input string tag, input logic ch,
                          input logic [W-1:0] d, input logic l);
      check({tag, ".v0"}, out0_valid, !ch);
      check({tag, ".v1"}, out1_valid, ch);
      check({tag, ".d0"}, out0_data, ch ? 4'h0 : d);
      check({tag, ".d1"}, out1_data, ch ? d : 4'h0);
      check({tag, ".l"}, ch ? out1_last : out0_last, l);
   endtask

   task automatic chk_cnt(input string tag);
      check({tag, ".c0"}, pkt_cnt0, e0 % 4);
      check({tag, ".c1"}, pkt_cnt1, e1 % 4);
   endtask

   // act: 0 none, 1 toggle cfg_ch, 2 drop cfg_en; applied at beat act_at
   task automatic run_pkt(input string tag, input int n, input int base,
                          input logic ch, input int act_at, input int act);
      logic [W-1:0] pd;
      for (int b = 0; b < n; b++) begin
         @(negedge clk);
         if (b > 0) exp_out(tag, ch, pd, 1'b0);
         pd = W'(base + b);
         drive(pd, b == n - 1);
         #1;
         check({tag, ".rdy"}, in_ready, 1'b1);
         if (b == act_at && act == 1) cfg_ch = ~cfg_ch;
         if (b == act_at && act == 2) cfg_en = 1'b0;
      end
      @(negedge clk);
      exp_out({tag, ".end"}, ch, pd, 1'b1);
      idle_in();
      if (ch) e1++;
      else    e0++;
      @(negedge clk);
      check({tag, ".idle0"}, out0_valid, 1'b0);
      check({tag, ".idle1"}, out1_valid, 1'b0);
      check({tag, ".busy"}, busy, 1'b0);
      chk_cnt(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      e0 = 0;
      e1 = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] pd;
      rst_n = 1'b0;
      cfg_en = 1'b1;
      cfg_mode = 1'b0;
      cfg_ch = 1'b0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      idle_in();
      #12;
      check("rst.v0", out0_valid, 1'b0);
      check("rst.v1", out1_valid, 1'b0);
      check("rst.rdy", in_ready, 1'b0);
      check("rst.busy", busy, 1'b0);
      chk_cnt("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // round-robin: packets alternate starting at channel 0
      for (int p = 0; p < 4; p++)
         run_pkt("rr", 3, 1 + 3 * p, p[0], -1, 0);

      // fixed channel, cfg_ch flips mid-packet without effect
      cfg_mode = 1'b1;
      cfg_ch = 1'b1;
      run_pkt("fix", 4, 5, 1'b1, 2, 1);
      run_pkt("fix2", 2, 9, 1'b0, -1, 0);

      // backpressure on channel 0 (rr pointer back at 0)
      cfg_mode = 1'b0;
      out0_ready = 1'b0;
      @(negedge clk);
      drive(4'hA, 1'b0);
      @(negedge clk);
      drive(4'hB, 1'b1);
      for (int i = 0; i < 5; i++) begin
         #1;
         exp_out("bp", 1'b0, 4'hA, 1'b0);
         check("bp.rdy", in_ready, 1'b0);
         check("bp.busy", busy, 1'b1);
         @(negedge clk);
      end
      out0_ready = 1'b1;
      #1;
      check("bp.rise", in_ready, 1'b1);
      @(negedge clk);
      exp_out("bp.b", 1'b0, 4'hB, 1'b1);
      idle_in();
      e0++;
      @(negedge clk);
      chk_cnt("bp");

      // back-to-back single-beat packets after a fresh reset
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) exp_out("sb", (i - 1) % 2 == 1, pd, 1'b1);
         pd = W'(i + 1);
         drive(pd, 1'b1);
         #1;
         check("sb.rdy", in_ready, 1'b1);
      end
      @(negedge clk);
      exp_out("sb.end", 1'b1, pd, 1'b1);
      idle_in();
      e0 += 3;
      e1 += 3;
      @(negedge clk);
      chk_cnt("sb");

      // drop enable mid-packet: packet completes, then stall
      run_pkt("en", 3, 2, 1'b0, 1, 2);
      @(negedge clk);
      drive(4'h7, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("en.rdy0", in_ready, 1'b0);
         check("en.busy", busy, 1'b0);
         check("en.v0", out0_valid, 1'b0);
         @(negedge clk);
      end
      cfg_en = 1'b1;
      #1;
      check("en.rdy1", in_ready, 1'b1);
      @(negedge clk);
      exp_out("en.pkt", 1'b1, 4'h7, 1'b1);
      idle_in();
      e1++;
      @(negedge clk);
      chk_cnt("en");

      // counter wrap: 5 packets on channel 0 with a 2-bit counter
      do_reset();
      cfg_mode = 1'b1;
      cfg_ch = 1'b0;
      for (int p = 0; p < 5; p++)
         run_pkt("wrap", 2, p, 1'b0, -1, 0);
      check("wrap.c0", pkt_cnt0, 2'd1);

      // async reset in the middle of a packet
      cfg_mode = 1'b0;
      @(negedge clk);
      drive(4'h3, 1'b0);
      @(negedge clk);
      drive(4'h4, 1'b0);
      check("ar.pre", out0_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar.v0", out0_valid, 1'b0);
      check("ar.d0", out0_data, 4'h0);
      check("ar.rdy", in_ready, 1'b0);
      check("ar.busy", busy, 1'b0);
      check("ar.c0", pkt_cnt0, 2'd0);
      e0 = 0;
      e1 = 0;
      @(negedge clk);
      idle_in();
      rst_n = 1'b1;
      run_pkt("ar.nxt", 2, 12, 1'b0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_pkt_sched.md
Name: demux_pkt_sched

Overview:
- Packet-aware scheduler and steering stage for the 1-to-2 data demultiplexer.
- Accepts one valid/ready beat stream with packet delimiters and picks a destination channel (0 or 1) at each packet start.
- Holds that channel for every beat of the packet and presents beats through one registered output stage.
- Sits between an upstream packet source and two downstream consumers. Counts packets delivered per channel.

Parameters:
- WIDTH, 4, data beat width in bits.
- CNT_W, 8, width of per-channel packet counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_en  in  1  scheduler enable; sampled only at packet boundaries.
- cfg_mode  in  1  0 = round-robin per packet, 1 = fixed channel.
- cfg_ch  in  1  channel used when cfg_mode=1.
- in_valid  in  1  input beat valid.
- in_data  in  WIDTH  input beat data.
- in_last  in  1  final beat of packet.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- out0_valid / out1_valid  out  1  channel beat valid.
- out0_data / out1_data  out  WIDTH  channel data; zero when that channel's valid is low.
- out0_last / out1_last  out  1  channel last flag; zero when that channel's valid is low.
- out0_ready / out1_ready  in  1  downstream ready per channel.
- pkt_cnt0 / pkt_cnt1  out  CNT_W  packets completed per channel.
- busy  out  1  high while mid-packet or while the holding register is valid.

Behaviour:
- Reset (async, rst_n=0): holding register empty, FSM=IDLE, rr pointer=0, pkt_cnt0=pkt_cnt1=0. All outN_valid/data/last=0, in_ready=0 while in reset, busy=0.
- Holding register: hold_valid, hold_data, hold_last, hold_ch.
  - outN_valid = hold_valid & (hold_ch==N); data and last are gated the same way.
  - Drain when outN_valid & outN_ready.
- in_ready:
  - In IDLE: in_ready = cfg_en & (!hold_valid | drain).
  - In PKT: in_ready = !hold_valid | drain.
  - Accepted beat loads the holding register on the next edge. Latency is 1 cycle from input accept to output valid. Full throughput: one beat/cycle when the target channel's ready stays high.
- FSM states IDLE and PKT:
  - IDLE, accept with in_last=0: choose channel, latch into pkt_ch, go to PKT.
  - IDLE, accept with in_last=1 (single-beat packet): choose channel, stay in IDLE.
  - PKT: every accepted beat uses pkt_ch; accept with in_last=1 goes to IDLE.
  - cfg_en, cfg_mode and cfg_ch changes mid-packet have no effect until the next IDLE acceptance.
- Channel choice (IDLE acceptance only):
  - mode 0: channel = rr pointer; the pointer toggles on each packet-start acceptance.
  - mode 1: channel = cfg_ch; the rr pointer is unchanged.
- Channel switch at a boundary: a last beat held for channel A may drain in the same cycle that the first beat for channel B is accepted. No bubble is required.
- Counters: pkt_cntN increments when outN_valid & outN_ready & outN_last. Wraps modulo 2^CNT_W with no saturation. Both counters may increment in different cycles only; a simultaneous increment is impossible by construction.
- Backpressure: the held beat stays stable (valid, data, last, channel unchanged) until drained. The non-target channel's ready is ignored.
- busy = (state==PKT) | hold_valid.
- Reset asserted mid-packet: everything returns to reset values immediately. The in-flight beat is discarded, no counter increments, and the next accepted beat is treated as a packet start with rr=0.

Test Plan:
- Reset then round-robin: mode 0, both readys=1; send 4 packets of 3 beats with data 1..12 → packets 1 and 3 on out0, packets 2 and 4 on out1. Each beat appears 1 cycle after acceptance. End with pkt_cnt0=2, pkt_cnt1=2.
- Fixed mode with mid-packet reconfig: mode 1, cfg_ch=1; send a 4-beat packet and toggle cfg_ch to 0 after beat 2 → all 4 beats on out1. The next packet goes to out0.
- Backpressure: out0_ready=0 for 5 cycles while the first beat (data 0xA) is held → out0_data stays 0xA, in_ready=0, out1_valid=0. The beat drains on the cycle ready rises.
- Single-beat packets back-to-back: mode 0, 6 packets with in_last=1 each → strict alternation 0,1,0,1,0,1, full throughput, FSM stays in IDLE.
- Enable at boundary: drop cfg_en mid-packet → the packet completes. in_ready then stays 0 until cfg_en=1, and busy=0 after drain.
- Counter wrap and async reset: CNT_W=2; 5 packets to out0 → pkt_cnt0=1. Assert rst_n=0 mid-packet → outputs are 0 at once with no clock edge, and the following packet goes to out0.
